// File: rtl/alu_exec_unit.sv
`default_nettype none
// alu_exec_unit: RV32I/RV32M execute stage with valid/ready handshake on both sides.
// ALU ops finish in one cycle; shift-add multiply and restoring divide iterate XLEN cycles.
module alu_exec_unit #(
  parameter int XLEN = 32,
  parameter int SHW  = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instruction,
  input  logic [1:0]      alu_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;
  typedef enum logic [4:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA, OP_OR, OP_AND,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU, OP_ILL
  } op_t;

  state_t state, state_next;
  op_t    dec_op, op_q;

  logic [6:0]        funct7;
  logic [2:0]        funct3;
  logic              unused_instr;
  logic              accept, is_mul, is_div, signed_div, div_zero, div_ovf, iterative;
  logic              a_sgn, b_sgn, neg_q, mul_q, last;
  logic [XLEN-1:0]   mag_a, mag_b, quick_res, fin_res, quot_s, rem_s;
  logic              quick_ill;
  logic [SHW-1:0]    cnt;
  logic [2*XLEN-1:0] acc, opnd, prod_s;
  logic [XLEN-1:0]   aux;
  logic [XLEN:0]     trial;

  assign funct7       = instruction[31:25];
  assign funct3       = instruction[14:12];
  assign unused_instr = ^{instruction[24:15], instruction[11:0]};

  always_comb begin
    dec_op = OP_ILL;
    case (alu_op)
      2'b00: dec_op = OP_ADD;
      2'b01: dec_op = OP_SUB;
      2'b10: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'd0: dec_op = OP_ADD;
            3'd1: dec_op = OP_SLL;
            3'd2: dec_op = OP_SLT;
            3'd3: dec_op = OP_SLTU;
            3'd4: dec_op = OP_XOR;
            3'd5: dec_op = OP_SRL;
            3'd6: dec_op = OP_OR;
            default: dec_op = OP_AND;
          endcase
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'd0) dec_op = OP_SUB;
          else if (funct3 == 3'd5) dec_op = OP_SRA;
        end else if (funct7 == 7'b0000001) begin
          case (funct3)
            3'd0: dec_op = OP_MUL;
            3'd1: dec_op = OP_MULH;
            3'd2: dec_op = OP_MULHSU;
            3'd3: dec_op = OP_MULHU;
            3'd4: dec_op = OP_DIV;
            3'd5: dec_op = OP_DIVU;
            3'd6: dec_op = OP_REM;
            default: dec_op = OP_REMU;
          endcase
        end
      end
      default: dec_op = OP_ILL;
    endcase
  end

  assign is_mul     = (dec_op == OP_MUL) || (dec_op == OP_MULH) ||
                      (dec_op == OP_MULHSU) || (dec_op == OP_MULHU);
  assign is_div     = (dec_op == OP_DIV) || (dec_op == OP_DIVU) ||
                      (dec_op == OP_REM) || (dec_op == OP_REMU);
  assign signed_div = (dec_op == OP_DIV) || (dec_op == OP_REM);
  assign div_zero   = (op_b == '0);
  assign div_ovf    = signed_div && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (&op_b);
  assign iterative  = is_mul || (is_div && !div_zero && !div_ovf);

  // Operand signs only matter for the signed flavours; magnitudes feed the iterative datapath.
  assign a_sgn = op_a[XLEN-1] && (signed_div || dec_op == OP_MULH || dec_op == OP_MULHSU);
  assign b_sgn = op_b[XLEN-1] && (signed_div || dec_op == OP_MULH);
  assign mag_a = a_sgn ? -op_a : op_a;
  assign mag_b = b_sgn ? -op_b : op_b;

  always_comb begin
    quick_res = '0;
    quick_ill = 1'b0;
    case (dec_op)
      OP_ADD:  quick_res = op_a + op_b;
      OP_SUB:  quick_res = op_a - op_b;
      OP_SLL:  quick_res = op_a << op_b[SHW-1:0];
      OP_SLT:  quick_res = {{(XLEN-1){1'b0}}, $signed(op_a) < $signed(op_b)};
      OP_SLTU: quick_res = {{(XLEN-1){1'b0}}, op_a < op_b};
      OP_XOR:  quick_res = op_a ^ op_b;
      OP_SRL:  quick_res = op_a >> op_b[SHW-1:0];
      OP_SRA:  quick_res = $unsigned($signed(op_a) >>> op_b[SHW-1:0]);
      OP_OR:   quick_res = op_a | op_b;
      OP_AND:  quick_res = op_a & op_b;
      // Only the divide special cases reach these two arms as single-cycle results.
      OP_DIV, OP_DIVU: quick_res = div_zero ? '1 : op_a;
      OP_REM, OP_REMU: quick_res = div_zero ? op_a : '0;
      OP_ILL:  quick_ill = 1'b1;
      default: quick_res = '0;
    endcase
  end

  assign trial  = {acc[2*XLEN-1:XLEN], acc[XLEN-1]} - {1'b0, aux};
  assign prod_s = neg_q ? -acc : acc;
  assign quot_s = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
  assign rem_s  = neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];

  always_comb begin
    fin_res = quot_s;
    case (op_q)
      OP_MUL:                        fin_res = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fin_res = prod_s[2*XLEN-1:XLEN];
      OP_REM, OP_REMU:               fin_res = rem_s;
      default:                       fin_res = quot_s;
    endcase
  end

  assign accept    = in_valid && (state == S_IDLE);
  assign in_ready  = (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign zero      = (result == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (in_valid) state_next = iterative ? S_BUSY : S_DONE;
      S_BUSY:  if (last) state_next = S_DONE;
      S_DONE:  if (out_ready) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_q    <= OP_ADD;
      neg_q   <= 1'b0;
      mul_q   <= 1'b0;
      last    <= 1'b0;
      cnt     <= '0;
      acc     <= '0;
      opnd    <= '0;
      aux     <= '0;
      result  <= '0;
      illegal <= 1'b0;
    end else if (accept) begin
      op_q  <= dec_op;
      mul_q <= is_mul;
      // Remainder follows the dividend; product and quotient follow the sign mismatch.
      neg_q <= (dec_op == OP_REM) ? a_sgn : (a_sgn ^ b_sgn);
      last  <= 1'b0;
      cnt   <= SHW'(XLEN-1);
      acc   <= is_mul ? '0 : {{XLEN{1'b0}}, mag_a};
      opnd  <= {{XLEN{1'b0}}, mag_a};
      aux   <= mag_b;
      if (!iterative) begin
        result  <= quick_res;
        illegal <= quick_ill;
      end
    end else if (state == S_BUSY) begin
      if (last) begin
        result  <= fin_res;
        illegal <= 1'b0;
      end else begin
        if (mul_q) begin
          if (aux[0]) acc <= acc + opnd;
          opnd <= opnd << 1;
          aux  <= aux >> 1;
        end else if (!trial[XLEN]) begin
          acc <= {trial[XLEN-1:0], acc[XLEN-2:0], 1'b1};
        end else begin
          acc <= {acc[2*XLEN-2:0], 1'b0};
        end
        if (cnt == '0) last <= 1'b1;
        else           cnt  <= cnt - 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// tb_alu_exec_unit: directed and random operations checked against an arithmetic reference model.
module tb_alu_exec_unit;
  localparam int XLEN = 32;

  logic        clk = 1'b0;
  logic        reset, in_valid, in_ready, out_valid, out_ready, zero, illegal;
  logic [31:0] instruction, op_a, op_b, result;
  logic [1:0]  alu_op;
  int          checks = 0, passes = 0, fails = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.XLEN(XLEN)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .alu_op(alu_op), .op_a(op_a), .op_b(op_b),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .zero(zero), .illegal(illegal)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic on the architectural definitions.
  function automatic void model(input logic [1:0] aop, input logic [6:0] f7, input logic [2:0] f3,
                                input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic ill, output int lat);
    longint sa, sb, ub;
    longint unsigned ua, ubu;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ua  = {32'b0, a};
    ubu = {32'b0, b};
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    r = '0; ill = 1'b0; lat = 0;
    if (aop == 2'b00) r = a + b;
    else if (aop == 2'b01) r = a - b;
    else if (aop == 2'b11) ill = 1'b1;
    else if (f7 == 7'h00) begin
      case (f3)
        3'd0: r = a + b;
        3'd1: r = a << b[4:0];
        3'd2: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        3'd3: r = (a < b) ? 32'd1 : 32'd0;
        3'd4: r = a ^ b;
        3'd5: r = a >> b[4:0];
        3'd6: r = a | b;
        default: r = a & b;
      endcase
    end else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
    else if (f7 == 7'h20 && f3 == 3'd5) r = $signed(a) >>> b[4:0];
    else if (f7 == 7'h01) begin
      lat = XLEN + 1;
      case (f3)
        3'd0: r = 32'(ua * ubu);
        3'd1: r = 32'((sa * sb) >>> 32);
        3'd2: r = 32'((sa * ub) >>> 32);
        3'd3: r = 32'((ua * ubu) >> 32);
        3'd4: if (b == 0) begin r = '1; lat = 0; end
              else if (ovf) begin r = a; lat = 0; end
              else r = 32'(sa / sb);
        3'd5: if (b == 0) begin r = '1; lat = 0; end
              else r = a / b;
        3'd6: if (b == 0) begin r = a; lat = 0; end
              else if (ovf) begin r = '0; lat = 0; end
              else r = 32'(sa % sb);
        default: if (b == 0) begin r = a; lat = 0; end
                 else r = a % b;
      endcase
    end else ill = 1'b1;
  endfunction

  task automatic run_op(input string tag, input logic [1:0] aop, input logic [6:0] f7,
                        input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    logic [31:0] er;
    logic        eill, stable;
    int          elat, lat;
    model(aop, f7, f3, a, b, er, eill, elat);
    @(negedge clk);
    check({tag, "/in_ready_idle"}, {31'b0, in_ready}, 32'd1);
    alu_op      = aop;
    instruction = {f7, 10'($urandom), f3, 12'($urandom)};
    op_a        = a;
    op_b        = b;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    op_a        = $urandom;
    op_b        = $urandom;
    alu_op      = 2'($urandom);
    instruction = $urandom;
    check({tag, "/in_ready_after_accept"}, {31'b0, in_ready}, 32'd0);
    lat = 0;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "/latency"}, 32'(lat), 32'(elat));
    check({tag, "/result"}, result, er);
    check({tag, "/zero"}, {31'b0, zero}, {31'b0, er == 32'd0});
    check({tag, "/illegal"}, {31'b0, illegal}, {31'b0, eill});
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || result !== er || in_ready !== 1'b0 ||
            illegal !== eill || zero !== (er == 32'd0)) stable = 1'b0;
      end
      check({tag, "/held_stable"}, {31'b0, stable}, 32'd1);
    end
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1; out_ready = 1'b0;
    check({tag, "/in_ready_after_handoff"}, {31'b0, in_ready}, 32'd1);
    check({tag, "/out_valid_after_handoff"}, {31'b0, out_valid}, 32'd0);
  endtask

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [6:0] tf7 [19];
    logic [2:0] tf3 [19];
    logic       seen;
    int         k;
    tf7 = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h20, 7'h20,
            7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h01, 7'h7F};
    tf3 = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd5,
            3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    alu_op = 2'b00; instruction = '0; op_a = '0; op_b = '0;
    repeat (3) @(negedge clk);
    check("reset/in_ready", {31'b0, in_ready}, 32'd1);
    check("reset/out_valid", {31'b0, out_valid}, 32'd0);
    check("reset/result", result, 32'd0);
    check("reset/zero", {31'b0, zero}, 32'd1);
    check("reset/illegal", {31'b0, illegal}, 32'd0);
    reset = 1'b0;

    run_op("add",   2'b10, 7'h00, 3'd0, 32'hFFFF_FFF0, 32'h4, 0);
    run_op("sra",   2'b10, 7'h20, 3'd5, 32'hFFFF_FFF0, 32'h4, 0);
    run_op("srl",   2'b10, 7'h00, 3'd5, 32'hFFFF_FFF0, 32'h4, 0);
    run_op("slt",   2'b10, 7'h00, 3'd2, 32'hFFFF_FFF0, 32'h4, 0);
    run_op("sltu",  2'b10, 7'h00, 3'd3, 32'hFFFF_FFF0, 32'h4, 0);
    run_op("sll",   2'b10, 7'h00, 3'd1, 32'hFFFF_FFF0, 32'h4, 0);
    run_op("xor",   2'b10, 7'h00, 3'd4, 32'hFFFF_FFF0, 32'h4, 0);
    run_op("or",    2'b10, 7'h00, 3'd6, 32'hFFFF_FFF0, 32'h4, 0);
    run_op("and",   2'b10, 7'h00, 3'd7, 32'hFFFF_FFF0, 32'h4, 0);
    run_op("sub55", 2'b10, 7'h20, 3'd0, 32'd5, 32'd5, 0);
    run_op("aluop_add", 2'b00, 7'h7F, 3'd7, 32'd10, 32'd20, 0);
    run_op("aluop_sub", 2'b01, 7'h7F, 3'd7, 32'd10, 32'd20, 0);
    run_op("mul",    2'b10, 7'h01, 3'd0, 32'hFFFF_FFFF, 32'h2, 0);
    run_op("mulh",   2'b10, 7'h01, 3'd1, 32'hFFFF_FFFF, 32'h2, 0);
    run_op("mulhu",  2'b10, 7'h01, 3'd3, 32'hFFFF_FFFF, 32'h2, 0);
    run_op("mulhsu", 2'b10, 7'h01, 3'd2, 32'hFFFF_FFFF, 32'h2, 0);
    run_op("div",  2'b10, 7'h01, 3'd4, -32'sd7, 32'd2, 0);
    run_op("rem",  2'b10, 7'h01, 3'd6, -32'sd7, 32'd2, 0);
    run_op("divu", 2'b10, 7'h01, 3'd5, 32'd100, 32'd7, 0);
    run_op("remu", 2'b10, 7'h01, 3'd7, 32'd100, 32'd7, 0);
    run_op("div_by0",  2'b10, 7'h01, 3'd4, 32'd1234, 32'd0, 0);
    run_op("remu_by0", 2'b10, 7'h01, 3'd7, 32'd9, 32'd0, 0);
    run_op("div_ovf",  2'b10, 7'h01, 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf",  2'b10, 7'h01, 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op("backpressure", 2'b10, 7'h01, 3'd0, 32'd12345, 32'd678, 10);
    run_op("illegal_aluop", 2'b11, 7'h00, 3'd0, 32'd3, 32'd4, 0);
    run_op("illegal_f7",    2'b10, 7'h7F, 3'd0, 32'd3, 32'd4, 3);

    // Abort a divide mid-iteration with an asynchronous reset.
    @(negedge clk);
    alu_op = 2'b10; instruction = {7'h01, 10'h0, 3'd4, 12'h0};
    op_a = -32'sd7; op_b = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (15) @(posedge clk);
    #2 reset = 1'b1;
    #2;
    check("abort/in_ready", {31'b0, in_ready}, 32'd1);
    check("abort/out_valid", {31'b0, out_valid}, 32'd0);
    check("abort/result", result, 32'd0);
    @(negedge clk); reset = 1'b0;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1'b1;
    end
    check("abort/no_out_valid", {31'b0, seen}, 32'd0);
    run_op("add_after_abort", 2'b10, 7'h00, 3'd0, 32'd3, 32'd4, 0);

    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 18);
      if ($urandom_range(0, 9) == 0)
        run_op("rand_aluop", 2'($urandom), 7'($urandom), 3'($urandom), pick_operand(), pick_operand(), 0);
      else
        run_op("rand_rtype", 2'b10, tf7[k], tf3[k], pick_operand(), pick_operand(), 0);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed no completion expected finish before 2000000");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
